// File: rtl/vline_fetch_pkg.sv
// Shared definitions for the video line-fetch scheduler: FSM states,
// timing defaults common with the timing generator, credit counter width.
package vline_fetch_pkg;

  localparam int unsigned LINE_WORDS_DEF = 600;   // H_ACT 1200 / 2 pixels per DDR word
  localparam int unsigned V_ACT_DEF      = 1920;  // active lines per frame
  localparam int unsigned CREDIT_W       = 3;     // lines_ready width, covers 1..7 buffers

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    WAIT_DONE,
    DONE
  } state_e;

endpackage

// File: rtl/vline_edge_det.sv
// Registered-history edge detector: one-cycle rise/fall strobes for a
// level signal coming from the timing generator.
module vline_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // Previous-cycle sample of the input level
  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/vline_fetch_sched.sv
// Line-fetch scheduler: issues one DDR line read per request/ack handshake,
// keeps at most NUM_LINEBUF lines buffered ahead of scan-out, restarts on
// vsync and pulses underflow when a line starts with nothing buffered.
// Optional feature macro: FB_SWAP_EN (alternate framebuffer base select).
module vline_fetch_sched
  import vline_fetch_pkg::*;
#(
  parameter int unsigned          LINE_WORDS  = LINE_WORDS_DEF,
  parameter int unsigned          V_ACT       = V_ACT_DEF,
  parameter int unsigned          NUM_LINEBUF = 2,
  parameter int unsigned          ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]    LINE_STRIDE = ADDR_W'(32'h0000_1000)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   fb_base,
`ifdef FB_SWAP_EN
  input  logic [ADDR_W-1:0]   fb_base_alt,
  input  logic                swap_req,
  output logic                swap_ack,
`endif
  input  logic                vsync,
  input  logic                de,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic [15:0]         rd_len,
  input  logic                rd_ack,
  input  logic                rd_done,
  output logic [2:0]          lines_ready,
  output logic                underflow,
  output logic                frame_busy
);

  localparam int unsigned        LIDX_W   = $clog2(V_ACT + 1);
  localparam logic [LIDX_W-1:0]  IDX_END  = LIDX_W'(V_ACT);
  localparam logic [LIDX_W-1:0]  IDX_LAST = LIDX_W'(V_ACT - 1);
  localparam logic [LIDX_W-1:0]  IDX_ONE  = LIDX_W'(1);
  localparam logic [CREDIT_W-1:0] NBUF    = CREDIT_W'(NUM_LINEBUF);
  localparam logic [CREDIT_W-1:0] CR_ONE  = CREDIT_W'(1);

  state_e                state_q;
  logic [LIDX_W-1:0]     line_idx_q;
  logic [ADDR_W-1:0]     addr_acc_q;
  logic [ADDR_W-1:0]     rd_addr_q;
  logic [CREDIT_W-1:0]   lines_ready_q, lines_ready_d;
  logic                  rd_req_q;
  logic                  underflow_q;
  logic                  frame_busy_q;
  logic                  stale_q;

  logic                  vsync_rise, unused_vsync_fall;
  logic                  de_rise, de_fall;
  logic                  frame_start;
  logic                  done_ok;
  logic [ADDR_W-1:0]     start_base;

  vline_edge_det u_vsync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (vsync),
    .rise_o (vsync_rise),
    .fall_o (unused_vsync_fall)
  );

  vline_edge_det u_de_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (de),
    .rise_o (de_rise),
    .fall_o (de_fall)
  );

  assign frame_start = vsync_rise & enable;
  // A completion is counted only for the current frame's request
  assign done_ok     = (state_q == WAIT_DONE) & rd_done & ~stale_q;

`ifdef FB_SWAP_EN
  logic sel_q, sel_d, swap_ack_q;

  // Base select toggles when a swap is requested at frame start
  always_comb begin
    sel_d      = swap_req ? ~sel_q : sel_q;
    start_base = sel_d ? fb_base_alt : fb_base;
  end

  // Select state and one-cycle acknowledge of an applied swap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q      <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      swap_ack_q <= frame_start & swap_req;
      if (frame_start) sel_q <= sel_d;
    end
  end

  assign swap_ack = swap_ack_q;
`else
  assign start_base = fb_base;
`endif

  // Credit count: fill on completion, drain on scan-out; both at once cancel
  always_comb begin
    lines_ready_d = lines_ready_q;
    if (frame_start) begin
      lines_ready_d = '0;
    end else if (done_ok && !de_fall) begin
      lines_ready_d = lines_ready_q + CR_ONE;
    end else if (!done_ok && de_fall && lines_ready_q != '0) begin
      lines_ready_d = lines_ready_q - CR_ONE;
    end
  end

  // Fetch FSM with registered request, address and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      line_idx_q    <= '0;
      addr_acc_q    <= '0;
      rd_addr_q     <= '0;
      lines_ready_q <= '0;
      rd_req_q      <= 1'b0;
      underflow_q   <= 1'b0;
      frame_busy_q  <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      lines_ready_q <= lines_ready_d;
      underflow_q   <= de_rise && (lines_ready_q == '0);
      if (rd_done && stale_q) stale_q <= 1'b0;

      if (frame_start) begin
        state_q      <= REQ;
        line_idx_q   <= '0;
        addr_acc_q   <= start_base;
        frame_busy_q <= 1'b1;
        rd_req_q     <= 1'b0;
        // An unacked request is simply dropped; an accepted one will still
        // report rd_done, which must be swallowed rather than counted.
        if ((state_q == WAIT_ACK && rd_ack) ||
            (state_q == WAIT_DONE && !done_ok)) begin
          stale_q <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: ;
          REQ: begin
            if (!enable) begin
              state_q <= IDLE;
            end else if (line_idx_q == IDX_END) begin
              state_q <= DONE;
            end else if (lines_ready_q < NBUF) begin
              rd_req_q   <= 1'b1;
              rd_addr_q  <= addr_acc_q;
              addr_acc_q <= addr_acc_q + LINE_STRIDE;
              state_q    <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (rd_ack) begin
              rd_req_q <= 1'b0;
              state_q  <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (done_ok) begin
              line_idx_q <= line_idx_q + IDX_ONE;
              if (line_idx_q == IDX_LAST) frame_busy_q <= 1'b0;
              state_q <= REQ;
            end
          end
          DONE: begin
            if (!enable) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign rd_len      = 16'(LINE_WORDS);
  assign lines_ready = lines_ready_q;
  assign underflow   = underflow_q;
  assign frame_busy  = frame_busy_q;

endmodule

// File: tb/tb_vline_fetch_sched.sv
// Directed bench for vline_fetch_sched (default parameters; FB_SWAP_EN optional).
module tb_vline_fetch_sched;

  logic        clk = 1'b0;
  logic        rst_n, enable, vsync, de, rd_ack, rd_done;
  logic [31:0] fb_base;
  logic        rd_req, underflow, frame_busy;
  logic [31:0] rd_addr;
  logic [15:0] rd_len;
  logic [2:0]  lines_ready;
`ifdef FB_SWAP_EN
  logic [31:0] fb_base_alt;
  logic        swap_req, swap_ack;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vline_fetch_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fb_base     (fb_base),
`ifdef FB_SWAP_EN
    .fb_base_alt (fb_base_alt),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
`endif
    .vsync       (vsync),
    .de          (de),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_len      (rd_len),
    .rd_ack      (rd_ack),
    .rd_done     (rd_done),
    .lines_ready (lines_ready),
    .underflow   (underflow),
    .frame_busy  (frame_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_req(input string tag, output bit ok);
    for (int k = 0; k < 20; k++) begin
      if (rd_req === 1'b1) break;
      tick();
    end
    ok = (rd_req === 1'b1);
    chk(tag, 32'(rd_req), 32'd1);
  endtask

  // Serve n lines back to back with immediate ack/done and a consume per line
  task automatic run_lines(input int n, input logic [31:0] base, input int start, output int reqs);
    int          bad;
    bit          ok;
    logic [31:0] exp_addr;
    bad  = 0;
    reqs = 0;
    for (int i = 0; i < n; i++) begin
      wait_req("run_req", ok);
      if (!ok) break;
      reqs++;
      exp_addr = base + 32'(start + i) * 32'h1000;
      if (rd_addr !== exp_addr) bad++;
      rd_ack = 1'b1; tick(); rd_ack = 1'b0;
      rd_done = 1'b1; tick(); rd_done = 1'b0;
      de = 1'b1; tick(); de = 1'b0; tick();
    end
    chk("run_addrs_bad", 32'(bad), 32'd0);
  endtask

  initial begin
    bit ok;
    int reqs;
    int extra;

    rst_n = 1'b0; enable = 1'b0; vsync = 1'b0; de = 1'b0;
    rd_ack = 1'b0; rd_done = 1'b0; fb_base = 32'h8000_0000;
`ifdef FB_SWAP_EN
    fb_base_alt = 32'h7000_0000; swap_req = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_rd_addr", rd_addr, 32'd0);
    chk("rst_rd_len", 32'(rd_len), 32'd600);
    chk("rst_lines_ready", 32'(lines_ready), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_frame_busy", 32'(frame_busy), 32'd0);

    // First frame: two lines fill both buffers, then stall
    rst_n = 1'b1; enable = 1'b1; tick();
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("fs_frame_busy", 32'(frame_busy), 32'd1);
    chk("fs_req_latency", 32'(rd_req), 32'd0);
    tick();
    chk("l0_req", 32'(rd_req), 32'd1);
    chk("l0_addr", rd_addr, 32'h8000_0000);
    repeat (4) tick();
    chk("l0_req_held", 32'(rd_req), 32'd1);
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    chk("l0_req_drop", 32'(rd_req), 32'd0);
    repeat (4) tick();
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("l0_lines_ready", 32'(lines_ready), 32'd1);
    tick();
    chk("l1_req", 32'(rd_req), 32'd1);
    chk("l1_addr", rd_addr, 32'h8000_1000);
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("l1_lines_ready", 32'(lines_ready), 32'd2);
    repeat (6) tick();
    chk("stall_no_req", 32'(rd_req), 32'd0);
    chk("stall_lines_ready", 32'(lines_ready), 32'd2);
    de = 1'b1; tick();
    chk("de_rise_no_uf", 32'(underflow), 32'd0);
    de = 1'b0; tick();
    chk("consume_lines_ready", 32'(lines_ready), 32'd1);
    chk("consume_req_latency", 32'(rd_req), 32'd0);
    tick();
    chk("l2_req", 32'(rd_req), 32'd1);
    chk("l2_addr", rd_addr, 32'h8000_2000);

    // rd_done and de fall in the same cycle cancel out
    de = 1'b1; tick();
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    rd_done = 1'b1; de = 1'b0; tick(); rd_done = 1'b0;
    chk("simul_lines_ready", 32'(lines_ready), 32'd1);
    tick();
    chk("l3_addr", rd_addr, 32'h8000_3000);

    // Underflow while the completion is withheld
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    de = 1'b1; tick();
    chk("uf_none_lr1", 32'(underflow), 32'd0);
    de = 1'b0; tick();
    chk("uf_drain_lr0", 32'(lines_ready), 32'd0);
    de = 1'b1; tick();
    chk("uf_pulse1", 32'(underflow), 32'd1);
    chk("uf_lr_stays0", 32'(lines_ready), 32'd0);
    tick();
    chk("uf_pulse1_end", 32'(underflow), 32'd0);
    de = 1'b0; tick();
    chk("uf_sat_lr0", 32'(lines_ready), 32'd0);
    de = 1'b1; tick();
    chk("uf_pulse2", 32'(underflow), 32'd1);
    de = 1'b0; tick();
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("uf_done_lr1", 32'(lines_ready), 32'd1);

    // Restart with an unacked request pending: it is discarded, no stale done
    wait_req("l4_req", ok);
    fb_base = 32'h1000_0000;
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("restart_req_drop", 32'(rd_req), 32'd0);
    chk("restart_lr0", 32'(lines_ready), 32'd0);

    // Full frame
    run_lines(1919, 32'h1000_0000, 0, reqs);
    wait_req("last_req", ok);
    reqs = reqs + (ok ? 1 : 0);
    chk("last_addr", rd_addr, 32'h1077_F000);
    chk("last_busy_before", 32'(frame_busy), 32'd1);
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("last_busy_after", 32'(frame_busy), 32'd0);
    de = 1'b1; tick(); de = 1'b0; tick();
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      if (rd_req === 1'b1) extra++;
      tick();
    end
    chk("frame_req_count", 32'(reqs), 32'd1920);
    chk("done_no_extra_req", 32'(extra), 32'd0);

    // Early vsync with an accepted request outstanding at line 700
    fb_base = 32'h4000_0000;
    vsync = 1'b1; tick(); vsync = 1'b0;
    run_lines(700, 32'h4000_0000, 0, reqs);
    chk("early_req_count", 32'(reqs), 32'd700);
    wait_req("l700_req", ok);
    chk("l700_addr", rd_addr, 32'h402B_C000);
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    tick();
    fb_base = 32'h5000_0000;
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("early_lr0", 32'(lines_ready), 32'd0);
    chk("early_busy", 32'(frame_busy), 32'd1);
    tick();
    chk("early_req", 32'(rd_req), 32'd1);
    chk("early_addr", rd_addr, 32'h5000_0000);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("stale_done_ignored", 32'(lines_ready), 32'd0);
    chk("stale_req_held", 32'(rd_req), 32'd1);
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("post_stale_lr", 32'(lines_ready), 32'd1);
    tick();
    chk("post_stale_addr", rd_addr, 32'h5000_1000);

    // Disable mid-line: line completes, then no further requests
    enable = 1'b0;
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("dis_lr2", 32'(lines_ready), 32'd2);
    de = 1'b1; tick(); de = 1'b0; tick();
    de = 1'b1; tick(); de = 1'b0; tick();
    repeat (5) tick();
    chk("dis_lr0", 32'(lines_ready), 32'd0);
    chk("dis_no_req", 32'(rd_req), 32'd0);
    vsync = 1'b1; tick(); vsync = 1'b0;
    repeat (3) tick();
    chk("dis_vsync_no_req", 32'(rd_req), 32'd0);

`ifdef FB_SWAP_EN
    enable = 1'b1; swap_req = 1'b1;
    vsync = 1'b1; tick(); vsync = 1'b0; swap_req = 1'b0;
    chk("swap_ack_pulse", 32'(swap_ack), 32'd1);
    tick();
    chk("swap_ack_end", 32'(swap_ack), 32'd0);
    chk("swap_addr", rd_addr, 32'h7000_0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
